// File: rtl/relu_maxpool.sv
// ReLU + 2x2 stride-2 max pooling over a word-addressed source map.
// Reads four source words per output through M0 and writes one pooled word through M1.
module relu_maxpool #(
  parameter int          IN_W     = 26,
  parameter int          IN_H     = 26,
  parameter logic [31:0] SRC_BASE = 32'h0,
  parameter logic [31:0] DST_BASE = 32'h0,
  parameter int          RD_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        finish,
  output logic        M0_R_req,
  output logic [31:0] M0_addr,
  input  logic [31:0] M0_R_data,
  output logic [3:0]  M0_W_req,
  output logic [31:0] M0_W_data,
  output logic        M1_R_req,
  output logic [31:0] M1_addr,
  input  logic [31:0] M1_R_data,
  output logic [3:0]  M1_W_req,
  output logic [31:0] M1_W_data
);

  localparam int          OUT_W    = IN_W / 2;
  localparam int          OUT_H    = IN_H / 2;
  localparam logic [15:0] LAST_COL = 16'(OUT_W - 1);
  localparam logic [15:0] LAST_ROW = 16'(OUT_H - 1);
  localparam logic [31:0] IN_W32   = 32'(IN_W);
  localparam logic [31:0] OUT_W32  = 32'(OUT_W);
  localparam logic [7:0]  LAT_LAST = 8'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  // state_q is the FSM state, kept as a plainly named register for checkers.
  state_t      state_q, state_d;
  logic [15:0] row_q, row_d;
  logic [15:0] col_q, col_d;
  logic [1:0]  elem_q, elem_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] max_q, max_d;
  logic        finish_q, finish_d;
  logic        m0_r_req_q, m0_r_req_d;
  logic [31:0] m0_addr_q, m0_addr_d;
  logic [3:0]  m1_w_req_q, m1_w_req_d;
  logic [31:0] m1_addr_q, m1_addr_d;
  logic [31:0] m1_w_data_q, m1_w_data_d;
  logic [31:0] sample_max;
  logic        unused_m1;

  assign unused_m1 = ^M1_R_data;

  // Element e of window (r,c): row 2r+e[1], column 2c+e[0].
  function automatic logic [31:0] src_addr(input logic [15:0] r, input logic [15:0] c,
                                           input logic [1:0] e);
    logic [31:0] word;
    word = {15'd0, r, e[1]} * IN_W32 + {15'd0, c, e[0]};
    return SRC_BASE + {word[29:0], 2'b00};
  endfunction

  function automatic logic [31:0] dst_addr(input logic [15:0] r, input logic [15:0] c);
    logic [31:0] word;
    word = {16'd0, r} * OUT_W32 + {16'd0, c};
    return DST_BASE + {word[29:0], 2'b00};
  endfunction

  // The first element of a window loads directly; later ones keep the signed maximum.
  assign sample_max = (elem_q == 2'd0 || $signed(M0_R_data) > $signed(max_q)) ? M0_R_data : max_q;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    elem_d      = elem_q;
    wait_d      = wait_q;
    max_d       = max_q;
    finish_d    = finish_q;
    m0_r_req_d  = 1'b0;
    m0_addr_d   = m0_addr_q;
    m1_w_req_d  = 4'b0000;
    m1_addr_d   = m1_addr_q;
    m1_w_data_d = m1_w_data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_RD_REQ;
          row_d      = 16'd0;
          col_d      = 16'd0;
          elem_d     = 2'd0;
          finish_d   = 1'b0;
          m0_r_req_d = 1'b1;
          m0_addr_d  = src_addr(16'd0, 16'd0, 2'd0);
        end
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
        wait_d  = 8'd0;
      end
      S_RD_WAIT: begin
        if (wait_q == LAT_LAST) begin
          max_d = sample_max;
          if (elem_q == 2'd3) begin
            state_d     = S_WRITE;
            m1_w_req_d  = 4'b1111;
            m1_addr_d   = dst_addr(row_q, col_q);
            m1_w_data_d = sample_max[31] ? 32'd0 : sample_max;
          end else begin
            state_d    = S_RD_REQ;
            elem_d     = elem_q + 2'd1;
            m0_r_req_d = 1'b1;
            m0_addr_d  = src_addr(row_q, col_q, elem_q + 2'd1);
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WRITE: begin
        if (row_q == LAST_ROW && col_q == LAST_COL) begin
          state_d  = S_DONE;
          finish_d = 1'b1;
        end else begin
          if (col_q == LAST_COL) begin
            col_d = 16'd0;
            row_d = row_q + 16'd1;
          end else begin
            col_d = col_q + 16'd1;
          end
          state_d    = S_RD_REQ;
          elem_d     = 2'd0;
          m0_r_req_d = 1'b1;
          m0_addr_d  = src_addr(row_d, col_d, 2'd0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= 16'd0;
      col_q       <= 16'd0;
      elem_q      <= 2'd0;
      wait_q      <= 8'd0;
      max_q       <= 32'd0;
      finish_q    <= 1'b0;
      m0_r_req_q  <= 1'b0;
      m0_addr_q   <= 32'd0;
      m1_w_req_q  <= 4'b0000;
      m1_addr_q   <= 32'd0;
      m1_w_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      elem_q      <= elem_d;
      wait_q      <= wait_d;
      max_q       <= max_d;
      finish_q    <= finish_d;
      m0_r_req_q  <= m0_r_req_d;
      m0_addr_q   <= m0_addr_d;
      m1_w_req_q  <= m1_w_req_d;
      m1_addr_q   <= m1_addr_d;
      m1_w_data_q <= m1_w_data_d;
    end
  end

  assign finish    = finish_q;
  assign M0_R_req  = m0_r_req_q;
  assign M0_addr   = m0_addr_q;
  assign M0_W_req  = 4'b0000;
  assign M0_W_data = 32'd0;
  assign M1_R_req  = 1'b0;
  assign M1_addr   = m1_addr_q;
  assign M1_W_req  = m1_w_req_q;
  assign M1_W_data = m1_w_data_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// Bench for relu_maxpool: source memory model with read latency, per-cycle timeline
// checks and a scoreboard of pooled words computed from the source map.
module tb_relu_maxpool;

  localparam int IN_W   = 26;
  localparam int IN_H   = 26;
  localparam int OUT_W  = IN_W / 2;
  localparam int OUT_H  = IN_H / 2;
  localparam int NOUT   = OUT_W * OUT_H;
  localparam int RD_LAT = 2;
  localparam int PER    = 4 * (1 + RD_LAT) + 1;
  localparam int TOTAL  = PER * NOUT;
  localparam logic [31:0] SRC_BASE = 32'h0000_1000;
  localparam logic [31:0] DST_BASE = 32'h0000_8000;

  localparam int M_QUIET = 0;
  localparam int M_RUN   = 1;
  localparam int M_DONE  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        finish;
  logic        M0_R_req;
  logic [31:0] M0_addr;
  logic [31:0] M0_R_data;
  logic [3:0]  M0_W_req;
  logic [31:0] M0_W_data;
  logic        M1_R_req;
  logic [31:0] M1_addr;
  logic [31:0] M1_R_data;
  logic [3:0]  M1_W_req;
  logic [31:0] M1_W_data;

  relu_maxpool #(
    .IN_W(IN_W), .IN_H(IN_H), .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .M0_R_req(M0_R_req), .M0_addr(M0_addr), .M0_R_data(M0_R_data),
    .M0_W_req(M0_W_req), .M0_W_data(M0_W_data),
    .M1_R_req(M1_R_req), .M1_addr(M1_addr), .M1_R_data(M1_R_data),
    .M1_W_req(M1_W_req), .M1_W_data(M1_W_data)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- source memory with RD_LAT read latency ----------------
  logic [31:0] src_mem [IN_W*IN_H];
  logic [31:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    int idx;
    for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    idx = int'((M0_addr - SRC_BASE) >> 2);
    if (M0_R_req && idx >= 0 && idx < IN_W*IN_H) rd_pipe[0] <= src_mem[idx];
    else rd_pipe[0] <= $urandom;
  end
  assign M0_R_data = rd_pipe[RD_LAT-1];

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_fail = 0;
  int mode = M_QUIET;
  int run_base = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc - run_base);
    end
  endtask

  function automatic logic [31:0] pool_ref(input int r, input int c);
    int idx [4];
    logic signed [31:0] m;
    idx[0] = (2*r) * IN_W + 2*c;
    idx[1] = idx[0] + 1;
    idx[2] = (2*r + 1) * IN_W + 2*c;
    idx[3] = idx[2] + 1;
    m = src_mem[idx[0]];
    for (int i = 1; i < 4; i++)
      if ($signed(src_mem[idx[i]]) > m) m = src_mem[idx[i]];
    return (m < 0) ? 32'd0 : m;
  endfunction

  task automatic fill_exp();
    exp_q.delete();
    for (int r = 0; r < OUT_H; r++)
      for (int c = 0; c < OUT_W; c++) exp_q.push_back(pool_ref(r, c));
  endtask

  task automatic fill_random();
    for (int i = 0; i < IN_W*IN_H; i++) src_mem[i] = $urandom;
  endtask

  // Per-cycle monitor, sampled 1 time unit after the rising edge.
  always @(posedge clk) begin
    int rel, k, o, e, r, c;
    logic exp_req, exp_wr;
    logic [31:0] w;
    #1;
    chk("m0_w_req", {28'd0, M0_W_req}, 32'd0);
    chk("m1_r_req", {31'd0, M1_R_req}, 32'd0);
    if (!rst) chk("m0_w_data", M0_W_data, 32'd0);
    if (mode == M_RUN) begin
      rel = cyc - run_base;
      exp_req = 1'b0;
      exp_wr = 1'b0;
      k = 0; e = 0;
      if (rel >= 1 && rel <= TOTAL) begin
        k = (rel - 1) / PER;
        o = (rel - 1) % PER;
        if (o == PER - 1) exp_wr = 1'b1;
        else if (o % (1 + RD_LAT) == 0) begin
          exp_req = 1'b1;
          e = o / (1 + RD_LAT);
        end
      end
      r = k / OUT_W;
      c = k % OUT_W;
      chk("m0_r_req", {31'd0, M0_R_req}, {31'd0, exp_req});
      if (exp_req) begin
        w = 32'((2*r + e/2) * IN_W + 2*c + e%2);
        chk("m0_addr", M0_addr, SRC_BASE + 4*w);
      end
      chk("m1_w_req", {28'd0, M1_W_req}, exp_wr ? 32'hF : 32'h0);
      if (exp_wr) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL scoreboard_empty: write %0d has no expected word", k);
        end else begin
          chk("m1_w_data", M1_W_data, exp_q.pop_front());
          chk("m1_addr", M1_addr, DST_BASE + 32'(4*k));
        end
      end
      chk("finish", {31'd0, finish}, {31'd0, rel > TOTAL});
    end else if (mode == M_DONE) begin
      chk("done_finish", {31'd0, finish}, 32'd1);
      chk("done_m0_r_req", {31'd0, M0_R_req}, 32'd0);
      chk("done_m1_w_req", {28'd0, M1_W_req}, 32'd0);
    end else begin
      chk("quiet_finish", {31'd0, finish}, 32'd0);
      chk("quiet_m0_r_req", {31'd0, M0_R_req}, 32'd0);
      chk("quiet_m1_w_req", {28'd0, M1_W_req}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_values(input string tag);
    chk({tag, "_finish"}, {31'd0, finish}, 32'd0);
    chk({tag, "_m0_r_req"}, {31'd0, M0_R_req}, 32'd0);
    chk({tag, "_m0_addr"}, M0_addr, 32'd0);
    chk({tag, "_m0_w_data"}, M0_W_data, 32'd0);
    chk({tag, "_m1_addr"}, M1_addr, 32'd0);
    chk({tag, "_m1_w_req"}, {28'd0, M1_W_req}, 32'd0);
    chk({tag, "_m1_w_data"}, M1_W_data, 32'd0);
  endtask

  // Starts a run with start high in cycle 0; optional abort (rst) and busy start pulse.
  task automatic run_map(input int abort_at, input int restart_at);
    @(negedge clk);
    start = 1'b1;
    run_base = cyc;
    mode = M_RUN;
    for (int n = 1; n <= TOTAL + 2; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == restart_at) start = 1'b1;
      if (n == restart_at + 1) start = 1'b0;
      if (n == abort_at) begin
        rst = 1'b1;
        mode = M_QUIET;
        break;
      end
    end
    if (abort_at > 0) begin
      @(negedge clk);
      check_reset_values("abort");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      exp_q.delete();
    end else begin
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      mode = M_DONE;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    M1_R_data = 32'd0;
    for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ramp
    for (int i = 0; i < IN_W*IN_H; i++) src_mem[i] = 32'(i) << 16;
    fill_exp();
    chk("model_ramp_first", exp_q[0], 32'h001B_0000);
    chk("model_ramp_last", exp_q[NOUT-1], 32'h02A3_0000);
    chk("model_ramp_count", 32'(exp_q.size()), 32'd169);
    run_map(0, 0);
    repeat (5) @(negedge clk);

    // all negative
    for (int i = 0; i < IN_W*IN_H; i++) src_mem[i] = 32'hFFFF_0000;
    fill_exp();
    chk("model_neg_first", exp_q[0], 32'h0);
    chk("model_neg_last", exp_q[NOUT-1], 32'h0);
    run_map(0, 0);
    repeat (5) @(negedge clk);

    // max position and sign windows, random elsewhere
    fill_random();
    src_mem[0]      = 32'hFFFB_0000;
    src_mem[1]      = 32'h0003_0000;
    src_mem[IN_W]   = 32'h8000_0000;
    src_mem[IN_W+1] = 32'h0002_8000;
    src_mem[2]      = 32'h8000_0000;
    src_mem[3]      = 32'hFFFF_FFFF;
    src_mem[IN_W+2] = 32'hFFFF_FFFE;
    src_mem[IN_W+3] = 32'hFFFF_FFFD;
    fill_exp();
    chk("model_win00", exp_q[0], 32'h0003_0000);
    chk("model_win01", exp_q[1], 32'h0);
    run_map(0, 0);
    repeat (5) @(negedge clk);

    // random map, ignored start while busy, then a start accepted in DONE
    fill_random();
    fill_exp();
    run_map(0, 1000);
    repeat (7) @(negedge clk);
    fill_exp();
    run_map(0, 0);
    repeat (5) @(negedge clk);

    // reset mid-run, then a complete run
    fill_random();
    fill_exp();
    run_map(500, 0);
    fill_exp();
    run_map(0, 0);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
